rf_arbiter: RTL
===============

Name: rf_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single-port register file.
- The register file has one shared address, a write enable, write data, and combinational read data. Its read data is forced to 0 while write enable is high.
- This block accepts one access per cycle from requester A or B, drives the register file from registered issue signals, and returns read data to the requester that issued the read.
- It sits between the two client blocks and the register file instance.

Parameters:
- WIDTH, 8, data width in bits of wr_data/rd_data.
- AW, 3, address width; the register file holds 2**AW entries.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A has an access pending.
- a_we  in  1  A access type: 1 = write, 0 = read.
- a_addr  in  AW  A address.
- a_wdata  in  WIDTH  A write data.
- a_ready  out  1  A access accepted this cycle.
- a_rvalid  out  1  A read data valid; one-cycle pulse.
- a_rdata  out  WIDTH  A read data.
- b_valid, b_we, b_addr, b_wdata, b_ready, b_rvalid, b_rdata  same as the A signals, for requester B.
- rf_wr_en  out  1  register file write enable.
- rf_addr  out  AW  register file address.
- rf_wr_data  out  WIDTH  register file write data.
- rf_rd_data  in  WIDTH  register file combinational read data.

Behaviour:
- Reset (async, rst=1): all outputs 0, including rf_wr_en, rf_addr, rf_wr_data, both ready/rvalid/rdata. Round-robin pointer set to "B last served", so A wins the first contention. In-flight accesses are discarded; no rvalid appears after reset releases.
- Accept stage (cycle N, combinational):
  - Only A valid -> a_ready=1.
  - Only B valid -> b_ready=1.
  - Both valid -> grant the requester not last served.
  - No ready is asserted without the matching valid. At most one ready per cycle.
  - A transfer occurs when valid && ready. The requester must hold valid/we/addr/wdata until ready.
- Issue stage (cycle N+1, registered):
  - On a transfer, rf_addr <= granted addr; rf_wr_en <= granted we; rf_wr_data <= granted wdata (0 for reads); issue tag <= A or B; read flag <= !we. Pointer <= granted requester.
  - With no transfer, rf_wr_en <= 0 and rf_addr/rf_wr_data hold their values.
- Response stage (cycle N+2, registered):
  - If the issue stage held a read: x_rdata <= rf_rd_data sampled at the end of N+1, and x_rvalid=1 for exactly one cycle, where x is the tag's requester.
  - The other requester's rvalid stays 0. rdata holds its value until the next read response to that requester.
- Writes: no response. Memory updates at the rising edge ending cycle N+1.
- Throughput and latency: one accepted access per cycle; read latency is 2 cycles from accept to rvalid.
- Read-after-write:
  - A write accepted at N followed by a read of the same address accepted at N+1 returns the new data.
  - A same-cycle conflict is impossible, since only one requester is granted per cycle.
- Read data is never sampled while rf_wr_en=1, which avoids the register file's forced-0 read.
- Pointer updates only on a transfer. Idle cycles do not change fairness.

Optional Feature:
- Macro: RF_ARB_STATS_EN.
- When defined, adds outputs a_cnt and b_cnt, 16 bits each. Each counts that requester's accepted transfers and saturates at 16'hFFFF. Both reset to 0 on rst.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then A write addr 3 data 8'h5A, then A read addr 3 -> rf_wr_en=1 with rf_addr=3 one cycle after the write accept; a_rvalid pulses 2 cycles after the read accept with a_rdata=8'h5A; b_rvalid stays 0.
- A and B both valid for 4 cycles (A reads addr 1, B reads addr 2) -> grants A,B,A,B; rvalid pulses alternate, returning data for addr 1 to A and addr 2 to B.
- Back-to-back: B write addr 7 data 8'hC3 accepted, then B read addr 7 accepted the next cycle -> b_rdata=8'hC3, not 8'h00.
- Assert rst for 1 cycle while a read is in the issue stage -> a_rvalid never pulses; all outputs are 0 during reset; after release, a simultaneous A/B request grants A first.
- Only B valid for 3 cycles, then A and B both valid -> B granted three times, then A wins the contention.
- With RF_ARB_STATS_EN defined: 5 A transfers and 2 B transfers -> a_cnt=5, b_cnt=2; both return to 0 after rst.

Source files
------------

// File: rtl/rf_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single-port register file.
// Define RF_ARB_STATS_EN to add saturating per-requester transfer counters a_cnt/b_cnt.
module rf_arbiter #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic             a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_ready,
    output logic             a_rvalid,
    output logic [WIDTH-1:0] a_rdata,
    input  logic             b_valid,
    input  logic             b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_ready,
    output logic             b_rvalid,
    output logic [WIDTH-1:0] b_rdata,
    output logic             rf_wr_en,
    output logic [AW-1:0]    rf_addr,
    output logic [WIDTH-1:0] rf_wr_data,
    input  logic [WIDTH-1:0] rf_rd_data
`ifdef RF_ARB_STATS_EN
    ,
    output logic [15:0]      a_cnt,
    output logic [15:0]      b_cnt
`endif
);

    logic             last_b_r;
    logic             iss_rd_r;
    logic             iss_b_r;
    logic             grant_a_s;
    logic             grant_b_s;
    logic             sel_we_s;
    logic [AW-1:0]    sel_addr_s;
    logic [WIDTH-1:0] sel_wdata_s;

    // Round-robin grant: on contention the requester not served last wins
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (rst) begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else if (a_valid && b_valid) begin
            grant_a_s = last_b_r;
            grant_b_s = !last_b_r;
        end else begin
            grant_a_s = a_valid;
            grant_b_s = b_valid;
        end
    end

    assign a_ready = grant_a_s;
    assign b_ready = grant_b_s;

    // Mux the granted request; read requests carry zero write data
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {AW{1'b0}};
        sel_wdata_s = {WIDTH{1'b0}};
        if (grant_b_s) begin
            sel_we_s    = b_we;
            sel_addr_s  = b_addr;
            sel_wdata_s = b_we ? b_wdata : {WIDTH{1'b0}};
        end else begin
            sel_we_s    = a_we;
            sel_addr_s  = a_addr;
            sel_wdata_s = a_we ? a_wdata : {WIDTH{1'b0}};
        end
    end

    // Issue stage: drive the register file and remember who owns a pending read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wr_en   <= 1'b0;
            rf_addr    <= {AW{1'b0}};
            rf_wr_data <= {WIDTH{1'b0}};
            iss_rd_r   <= 1'b0;
            iss_b_r    <= 1'b0;
            last_b_r   <= 1'b1;
        end else if (grant_a_s || grant_b_s) begin
            rf_wr_en   <= sel_we_s;
            rf_addr    <= sel_addr_s;
            rf_wr_data <= sel_wdata_s;
            iss_rd_r   <= !sel_we_s;
            iss_b_r    <= grant_b_s;
            last_b_r   <= grant_b_s;
        end else begin
            rf_wr_en   <= 1'b0;
            iss_rd_r   <= 1'b0;
        end
    end

    // Response stage: capture read data while rf_wr_en is low and steer it by tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= {WIDTH{1'b0}};
            b_rdata  <= {WIDTH{1'b0}};
        end else begin
            a_rvalid <= iss_rd_r && !iss_b_r;
            b_rvalid <= iss_rd_r && iss_b_r;
            if (iss_rd_r && !iss_b_r) begin
                a_rdata <= rf_rd_data;
            end
            if (iss_rd_r && iss_b_r) begin
                b_rdata <= rf_rd_data;
            end
        end
    end

`ifdef RF_ARB_STATS_EN
    // Saturating accepted-transfer counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt <= 16'h0000;
            b_cnt <= 16'h0000;
        end else begin
            if (grant_a_s && (a_cnt != 16'hFFFF)) begin
                a_cnt <= a_cnt + 16'd1;
            end
            if (grant_b_s && (b_cnt != 16'hFFFF)) begin
                b_cnt <= b_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
